// File: rtl/dvp_cam_tx_if.sv
// DVP camera-side bus: 16-bit FWFT pixel source in, 8-bit DVP byte stream out.
interface dvp_cam_tx_if;
   logic [15:0] data_16b;
   logic        data_16b_valid;
   logic        data_16b_rd;
   logic [7:0]  cmos_data;
   logic        cmos_href;
   logic        cmos_vsyn;

   // master: the stream generator (pops pixels, drives DVP lines)
   modport master (
      input  data_16b,
      input  data_16b_valid,
      output data_16b_rd,
      output cmos_data,
      output cmos_href,
      output cmos_vsyn
   );

   // slave: pixel source plus DVP-input consumer
   modport slave (
      output data_16b,
      output data_16b_valid,
      input  data_16b_rd,
      input  cmos_data,
      input  cmos_href,
      input  cmos_vsyn
   );
endinterface

// File: rtl/dvp_cam_tx.sv
// DVP camera-side transmitter: frames a 16-bit pixel source (or an internal
// line/pixel test pattern) into vsyn/href/byte timing, high byte first.
module dvp_cam_tx #(
   parameter int unsigned H_ACTIVE      = 640,
   parameter int unsigned H_BLANK       = 144,
   parameter int unsigned V_ACTIVE      = 480,
   parameter int unsigned VSYNC_LINES   = 3,
   parameter int unsigned V_BACK_LINES  = 17,
   parameter int unsigned V_FRONT_LINES = 10
) (
   input  logic             cmos_pclk,
   input  logic             rst,
   input  logic             frame_en,
   input  logic             pattern_mode,
   dvp_cam_tx_if.master     bus,
   output logic             frame_busy,
   output logic             underflow,
   output logic [7:0]       frame_cnt
);

   localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
   localparam int unsigned MAX_LINES =
      (VSYNC_LINES > V_BACK_LINES) ?
         ((VSYNC_LINES  > V_FRONT_LINES) ? VSYNC_LINES  : V_FRONT_LINES) :
         ((V_BACK_LINES > V_FRONT_LINES) ? V_BACK_LINES : V_FRONT_LINES);
   localparam int unsigned CW_RAW = $clog2(MAX_LINES * LINE_LEN);
   localparam int unsigned CW     = (CW_RAW > 9) ? CW_RAW : 9;
   localparam int unsigned LW_RAW = $clog2(V_ACTIVE);
   localparam int unsigned LW     = (LW_RAW > 8) ? LW_RAW : 8;

   localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_LINES   * LINE_LEN - 1);
   localparam logic [CW-1:0] VB_LAST  = CW'(V_BACK_LINES  * LINE_LEN - 1);
   localparam logic [CW-1:0] VF_LAST  = CW'(V_FRONT_LINES * LINE_LEN - 1);
   localparam logic [CW-1:0] ACT_LAST = CW'(2 * H_ACTIVE - 1);
   localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBACK,
      ACTIVE,
      HBLANK,
      VFRONT
   } state_t;

   state_t          state;
   logic [CW-1:0]   cyc_cnt;
   logic [LW-1:0]   line_cnt;
   logic            pat_mode;
   logic [7:0]      lo_hold;

   logic            launch_hi;
   logic            launch_lo;
   logic [7:0]      pat_line;
   logic [7:0]      pat_pix;
   logic [15:0]     nxt_pixel;

   // Decide whether the coming edge launches a high byte (new pixel) or the
   // held low byte, and which line/pixel index that pixel belongs to.
   always_comb begin
      launch_hi = 1'b0;
      launch_lo = 1'b0;
      pat_line  = 8'(line_cnt);
      pat_pix   = 8'd0;
      unique case (state)
         VBACK: begin
            launch_hi = (cyc_cnt == VB_LAST);
            pat_line  = 8'd0;
         end
         ACTIVE: begin
            if (cyc_cnt[0]) begin
               launch_hi = (cyc_cnt != ACT_LAST);
               pat_pix   = 8'(cyc_cnt >> 1) + 8'd1;
            end else begin
               launch_lo = 1'b1;
            end
         end
         HBLANK: begin
            launch_hi = (cyc_cnt == HB_LAST) && (line_cnt != LINE_LAST);
            pat_line  = 8'(line_cnt + LW'(1));
         end
         default: ;
      endcase
   end

   assign nxt_pixel = pat_mode ? {pat_line, pat_pix}
                    : (bus.data_16b_valid ? bus.data_16b : '0);

   assign bus.data_16b_rd = ~rst & launch_hi & ~pat_mode;

   // Frame FSM with registered DVP outputs; each branch sets the outputs for
   // the state being entered so they line up with the state register.
   always_ff @(posedge cmos_pclk) begin
      if (rst) begin
         state         <= IDLE;
         cyc_cnt       <= '0;
         line_cnt      <= '0;
         pat_mode      <= 1'b0;
         lo_hold       <= '0;
         bus.cmos_data <= '0;
         bus.cmos_href <= 1'b0;
         bus.cmos_vsyn <= 1'b0;
         frame_busy    <= 1'b0;
         underflow     <= 1'b0;
         frame_cnt     <= '0;
      end else begin
         bus.cmos_data <= '0;
         bus.cmos_href <= 1'b0;
         bus.cmos_vsyn <= 1'b0;
         frame_busy    <= 1'b1;
         cyc_cnt       <= cyc_cnt + CW'(1);

         if (launch_hi) begin
            bus.cmos_data <= nxt_pixel[15:8];
            lo_hold       <= nxt_pixel[7:0];
            if (!pat_mode && !bus.data_16b_valid)
               underflow <= 1'b1;
         end else if (launch_lo) begin
            bus.cmos_data <= lo_hold;
         end

         unique case (state)
            IDLE: begin
               cyc_cnt    <= '0;
               frame_busy <= 1'b0;
               if (frame_en) begin
                  state         <= VSYNC;
                  bus.cmos_vsyn <= 1'b1;
                  frame_busy    <= 1'b1;
                  frame_cnt     <= frame_cnt + 8'd1;
                  underflow     <= 1'b0;
                  pat_mode      <= pattern_mode;
               end
            end
            VSYNC: begin
               if (cyc_cnt == VS_LAST) begin
                  state   <= VBACK;
                  cyc_cnt <= '0;
               end else begin
                  bus.cmos_vsyn <= 1'b1;
               end
            end
            VBACK: begin
               if (cyc_cnt == VB_LAST) begin
                  state         <= ACTIVE;
                  cyc_cnt       <= '0;
                  line_cnt      <= '0;
                  bus.cmos_href <= 1'b1;
               end
            end
            ACTIVE: begin
               if (cyc_cnt == ACT_LAST) begin
                  state   <= HBLANK;
                  cyc_cnt <= '0;
               end else begin
                  bus.cmos_href <= 1'b1;
               end
            end
            HBLANK: begin
               if (cyc_cnt == HB_LAST) begin
                  cyc_cnt <= '0;
                  if (line_cnt == LINE_LAST) begin
                     state <= VFRONT;
                  end else begin
                     state         <= ACTIVE;
                     line_cnt      <= line_cnt + LW'(1);
                     bus.cmos_href <= 1'b1;
                  end
               end
            end
            VFRONT: begin
               if (cyc_cnt == VF_LAST) begin
                  cyc_cnt <= '0;
                  if (frame_en) begin
                     state         <= VSYNC;
                     bus.cmos_vsyn <= 1'b1;
                     frame_cnt     <= frame_cnt + 8'd1;
                     underflow     <= 1'b0;
                     pat_mode      <= pattern_mode;
                  end else begin
                     state      <= IDLE;
                     frame_busy <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dvp_cam_tx.sv
// Randomized bench for dvp_cam_tx: a frame-position model predicts every
// output from arithmetic on the cycle offset within the frame.
module tb_dvp_cam_tx;

   localparam int H_ACTIVE      = 4;
   localparam int H_BLANK       = 3;
   localparam int V_ACTIVE      = 2;
   localparam int VSYNC_LINES   = 1;
   localparam int V_BACK_LINES  = 1;
   localparam int V_FRONT_LINES = 1;
   localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
   localparam int VS_LEN    = VSYNC_LINES * LINE_LEN;
   localparam int A0        = (VSYNC_LINES + V_BACK_LINES) * LINE_LEN;
   localparam int ACT_LEN   = V_ACTIVE * LINE_LEN;
   localparam int FRAME_LEN = (VSYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES) * LINE_LEN;

   logic       cmos_pclk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_en = 1'b0;
   logic       pattern_mode = 1'b0;
   logic       frame_busy;
   logic       underflow;
   logic [7:0] frame_cnt;

   dvp_cam_tx_if bus();

   dvp_cam_tx #(
      .H_ACTIVE(H_ACTIVE),
      .H_BLANK(H_BLANK),
      .V_ACTIVE(V_ACTIVE),
      .VSYNC_LINES(VSYNC_LINES),
      .V_BACK_LINES(V_BACK_LINES),
      .V_FRONT_LINES(V_FRONT_LINES)
   ) dut (
      .cmos_pclk(cmos_pclk),
      .rst(rst),
      .frame_en(frame_en),
      .pattern_mode(pattern_mode),
      .bus(bus),
      .frame_busy(frame_busy),
      .underflow(underflow),
      .frame_cnt(frame_cnt)
   );

   always #5 cmos_pclk = ~cmos_pclk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model state
   bit          m_armed = 0;
   bit          m_in_frame = 0;
   bit          m_pmode = 0;
   bit          m_uf = 0;
   int          m_t = 0;
   int          m_cnt = 0;
   logic [15:0] m_pix = '0;

   // bench drive state
   bit          drv_rst = 1;
   bit          drv_en = 0;
   bit          drv_pm = 1;
   int          vmode = 0;      // 0 always valid, 1 random, 2 drop line0 pixel2
   logic [15:0] src_pix = 16'hA1B2;
   bit          pop_pending = 0;

   function automatic bit act_pos(input int t, output int line, output int pix, output int phase);
      int r, c;
      line = 0; pix = 0; phase = 0;
      if (t < A0 || t >= A0 + ACT_LEN) return 0;
      r = t - A0;
      line = r / LINE_LEN;
      c = r % LINE_LEN;
      if (c >= 2 * H_ACTIVE) return 0;
      pix = c / 2;
      phase = c % 2;
      return 1;
   endfunction

   task automatic model_start();
      m_in_frame = 1;
      m_t = 0;
      m_cnt = (m_cnt + 1) % 256;
      m_uf = 0;
      m_pmode = pattern_mode;
   endtask

   task automatic run_cycle();
      int l, p, ph, nl, np, nph;
      bit eh, nact, erd, vld;
      logic [15:0] px;
      logic [7:0] eb;
      @(negedge cmos_pclk);
      if (m_armed) begin
         check_val("vsyn", 32'(bus.cmos_vsyn), 32'(m_in_frame && m_t < VS_LEN));
         eh = m_in_frame && act_pos(m_t, l, p, ph);
         check_val("href", 32'(bus.cmos_href), 32'(eh));
         check_val("frame_busy", 32'(frame_busy), 32'(m_in_frame));
         check_val("underflow", 32'(underflow), 32'(m_uf));
         check_val("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
         if (eh) begin
            px = m_pmode ? {8'(l), 8'(p)} : m_pix;
            eb = (ph == 0) ? px[15:8] : px[7:0];
            check_val("data", 32'(bus.cmos_data), 32'(eb));
         end else if (!m_in_frame) begin
            check_val("data_idle", 32'(bus.cmos_data), 32'd0);
         end
      end
      if (pop_pending) begin
         src_pix = 16'($urandom);
         pop_pending = 0;
      end
      nact = m_in_frame && act_pos(m_t + 1, nl, np, nph) && nph == 0;
      case (vmode)
         1: vld = ($urandom % 4) != 0;
         2: vld = !(nact && nl == 0 && np == 2);
         default: vld = 1;
      endcase
      rst = drv_rst;
      frame_en = drv_en;
      pattern_mode = drv_pm;
      bus.data_16b = src_pix;
      bus.data_16b_valid = vld;
      #1;
      erd = m_armed && !rst && nact && !m_pmode;
      if (m_armed || rst) check_val("rd", 32'(bus.data_16b_rd), 32'(erd));
      pop_pending = bus.data_16b_rd && bus.data_16b_valid;
      // emulate the coming rising edge
      if (rst) begin
         m_armed = 1;
         m_in_frame = 0;
         m_t = 0;
         m_cnt = 0;
         m_uf = 0;
      end else if (m_armed) begin
         if (erd) begin
            m_pix = vld ? bus.data_16b : 16'h0000;
            if (!vld) m_uf = 1;
         end
         if (!m_in_frame) begin
            if (frame_en) model_start();
         end else begin
            m_t++;
            if (m_t == FRAME_LEN) begin
               if (frame_en) model_start();
               else m_in_frame = 0;
            end
         end
      end
   endtask

   initial begin
      bus.data_16b = '0;
      bus.data_16b_valid = 1'b0;

      // reset, then continuous pattern frames
      drv_rst = 1; drv_en = 0; drv_pm = 1; vmode = 0;
      repeat (3) run_cycle();
      drv_rst = 0; drv_en = 1;
      repeat (125) run_cycle();

      // pixel source, always valid
      drv_pm = 0; vmode = 0;
      repeat (130) run_cycle();

      // starve the third pixel of line 0
      vmode = 2;
      repeat (130) run_cycle();

      // random valid
      vmode = 1;
      repeat (130) run_cycle();

      // drop frame_en during line 0: frame completes, then idle
      vmode = 0;
      for (int i = 0; i < 200 && !(m_in_frame && m_t >= A0 && m_t < A0 + LINE_LEN); i++)
         run_cycle();
      drv_en = 0;
      repeat (100) run_cycle();

      // reset pulse mid-active, restart immediately after
      drv_en = 1;
      repeat (30) run_cycle();
      drv_rst = 1;
      run_cycle();
      drv_rst = 0;
      repeat (100) run_cycle();

      // long continuous run to wrap frame_cnt through 255 -> 0
      vmode = 1;
      repeat (256 * FRAME_LEN + 20) run_cycle();

      // random control
      for (int i = 0; i < 2500; i++) begin
         drv_rst = ($urandom % 400) == 0;
         if (($urandom % 70) == 0) drv_en = !drv_en;
         if (($urandom % 90) == 0) drv_pm = !drv_pm;
         vmode = (($urandom % 3) == 0) ? 0 : 1;
         run_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dvp_cam_tx.md
Name: dvp_cam_tx

Overview:
- Generates a DVP camera-side stream (cmos_data, cmos_href, cmos_vsyn) from a 16-bit pixel source, or from an internal test pattern.
- Sits in the sim/loopback path in front of the camera receiver, standing in for the sensor. It also drives processed frames out of the pipeline to a DVP-input consumer.
- Each 16-bit pixel is sent as two bytes, high byte first, matching the receiver's packing order.

Parameters:
- H_ACTIVE, 640, pixels per line (>=1); the line is active for 2*H_ACTIVE cycles.
- H_BLANK, 144, href-low cycles after each active line (>=1).
- V_ACTIVE, 480, active lines per frame (>=1).
- VSYNC_LINES, 3, line periods with vsyn high (>=1).
- V_BACK_LINES, 17, line periods between vsyn fall and the first href (>=1).
- V_FRONT_LINES, 10, line periods after the last active line (>=1).
- LINE_LEN, derived, equals 2*H_ACTIVE + H_BLANK cycles.

Ports:
- cmos_pclk  in  1  the only clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_en  in  1  high: run frames continuously; low: stop after the current frame.
- pattern_mode  in  1  1 = internal test pattern; 0 = pixel source.
- data_16b  in  16  source pixel, first-word-fall-through.
- data_16b_valid  in  1  source has a pixel on data_16b.
- data_16b_rd  out  1  pop strobe; the pixel is consumed on this edge.
- cmos_data  out  8  byte stream.
- cmos_href  out  1  line valid.
- cmos_vsyn  out  1  frame sync, active high.
- frame_busy  out  1  high from VSYNC entry until return to IDLE.
- underflow  out  1  sticky pixel-starvation flag.
- frame_cnt  out  8  frames started; wraps 255->0.

Behaviour:
- Reset: all of the following are 0 on the edge where rst=1 and held while rst=1: cmos_data, cmos_href, cmos_vsyn, data_16b_rd, frame_busy, underflow, frame_cnt. All counters clear and the FSM goes to IDLE. Reset mid-frame aborts the frame immediately, with no completion.
- Output timing: cmos_data, cmos_href, cmos_vsyn, frame_busy and underflow are registered. data_16b_rd is combinational from state and counters.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT. cyc_cnt counts cycles within the state, line_cnt counts lines.
- IDLE: all outputs low. When frame_en=1, enter VSYNC next edge and increment frame_cnt.
- VSYNC: cmos_vsyn=1 for VSYNC_LINES*LINE_LEN cycles, then VBACK.
- VBACK: cmos_vsyn=0 for V_BACK_LINES*LINE_LEN cycles, then ACTIVE with line_cnt=0.
- ACTIVE: cmos_href=1 for 2*H_ACTIVE cycles, then HBLANK.
- HBLANK: href=0 for H_BLANK cycles. Then, if line_cnt==V_ACTIVE-1, go to VFRONT; otherwise line_cnt+1 and back to ACTIVE.
- VFRONT: lasts V_FRONT_LINES*LINE_LEN cycles. At its last cycle, frame_en=1 goes to VSYNC (frame_cnt+1, no idle gap); otherwise go to IDLE.
- frame_en sampling: sampled only in IDLE and on the last VFRONT cycle. Deassertion mid-frame completes the frame.
- Byte phases: phase toggles each ACTIVE cycle and starts at 0 on each line.
  - Phase 0: cmos_data = pixel[15:8].
  - Phase 1: cmos_data = pixel[7:0], taken from a hold register.
- Pixel fetch (pattern_mode=0):
  - data_16b_rd=1 on the edge that launches each phase-0 byte, i.e. H_ACTIVE pulses per line and 0 elsewhere.
  - The high byte is registered directly from data_16b on that edge; the low byte is saved to the hold register.
- Starvation: if data_16b_rd=1 while data_16b_valid=0, the pixel sent is 0x0000, href timing is unchanged, and underflow is set. underflow clears on VSYNC entry or reset.
- pattern_mode=1:
  - data_16b_rd stays 0 and the source is ignored.
  - pixel = {line_cnt[7:0], pix_idx[7:0]}, where pix_idx is the pixel index within the line.
  - Underflow is never set.
  - pattern_mode is sampled at VSYNC entry and held for the frame.
- frame_busy=1 in every state except IDLE.

Test Plan (H_ACTIVE=4, H_BLANK=3, V_ACTIVE=2, VSYNC_LINES=1, V_BACK_LINES=1, V_FRONT_LINES=1, so LINE_LEN=11):
1. Reset, then frame_en=1 held, pattern_mode=1 -> vsyn high 11 cycles, low 11; href high 8, low 3, high 8, low 3; front 11; next vsyn rises exactly 55 cycles after the first; frame_cnt 1 then 2.
2. Pattern bytes -> line 0 cmos_data = 00,00,00,01,00,02,00,03; line 1 = 01,00,01,01,01,02,01,03; data_16b_rd never 1.
3. pattern_mode=0, source always valid, supplying 0xA1B2, 0xC3D4, ... -> bytes A1,B2,C3,D4,... in order; exactly 4 rd pulses per line, on phase-0 edges; underflow stays 0.
4. pattern_mode=0, data_16b_valid=0 during the 3rd pixel of line 0 -> that pixel sent as 00,00; underflow=1 until the next VSYNC entry, then 0; href timing unchanged.
5. frame_en dropped during line 0 -> frame completes through VFRONT, FSM returns to IDLE, frame_busy falls, no further vsyn; frame_cnt=1.
6. rst pulsed mid-ACTIVE -> next edge: all outputs 0 and frame_cnt=0. With frame_en=1, VSYNC restarts the cycle after rst falls.
